// File: rtl/hl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hl_pkg
// Description : Shared FSM state and command-priority encoding for the
//               half-life timer.
// Revision    : 1.0 - initial release
// ============================================================================
package hl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DECAY   = 2'd1,
        EXPIRED = 2'd2
    } hl_state_t;

    localparam logic [2:0] c_cmd_none = 3'd0;
    localparam logic [2:0] c_cmd_load = 3'd1;
    localparam logic [2:0] c_cmd_up   = 3'd2;
    localparam logic [2:0] c_cmd_down = 3'd3;
    localparam logic [2:0] c_cmd_tick = 3'd4;

    // Exactly one command wins per cycle: load > up > down > decay tick.
    function automatic logic [2:0] f_pick_cmd(
        input logic load,
        input logic up,
        input logic down,
        input logic tick
    );
        logic [2:0] v_cmd;
        if (load)      v_cmd = c_cmd_load;
        else if (up)   v_cmd = c_cmd_up;
        else if (down) v_cmd = c_cmd_down;
        else if (tick) v_cmd = c_cmd_tick;
        else           v_cmd = c_cmd_none;
        return v_cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hl_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : hl_prescaler
// Description : Decay interval counter; ticks when the count reaches period.
// Revision    : 1.0 - initial release
// ============================================================================
module hl_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [PRE_W-1:0] period,
    output logic             tick
);

    logic [PRE_W-1:0] r_cnt;
    logic             w_hit;

    // >= keeps the interval bounded if period shrinks below the running count.
    assign w_hit = (r_cnt >= period);
    assign tick  = w_hit & ~clr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PRE_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/halflife_timer_n.sv
`default_nettype none
// ============================================================================
// Module      : halflife_timer_n
// Description : Up/down counter with load and a periodic halving decay mode.
// Revision    : 1.0 - initial release
// ============================================================================
module halflife_timer_n
    import hl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8,
    parameter int WRAP  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             up,
    input  logic             down,
    input  logic             decay,
    input  logic [WIDTH-1:0] in,
    input  logic [PRE_W-1:0] period,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             halved,
    output logic             expired
);

    localparam logic [WIDTH-1:0] c_ones = '1;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    hl_state_t        r_state;
    hl_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic             r_zero;
    logic             r_halved;
    logic             r_expired;
    logic             w_halve;
    logic             w_clr;
    logic             w_tick;
    logic [2:0]       w_cmd;

    assign w_clr = ~decay | load | (r_state != DECAY);

    hl_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .period (period),
        .tick   (w_tick)
    );

    generate
        if (WRAP != 0) begin : g_wrap
            assign w_inc = r_out + c_one;
            assign w_dec = r_out - c_one;
        end else begin : g_sat
            assign w_inc = (r_out == c_ones) ? r_out : r_out + c_one;
            assign w_dec = (r_out == '0)     ? r_out : r_out - c_one;
        end
    endgenerate

    always_comb begin
        w_out_nxt = r_out;
        w_halve   = 1'b0;
        w_cmd     = f_pick_cmd(load, up, down, w_tick);
        case (w_cmd)
            c_cmd_load: w_out_nxt = in;
            c_cmd_up:   w_out_nxt = w_inc;
            c_cmd_down: w_out_nxt = w_dec;
            c_cmd_tick: begin
                w_out_nxt = r_out >> 1;
                w_halve   = 1'b1;
            end
            default:    w_out_nxt = r_out;
        endcase
    end

    // Transitions look at the post-command value so a load/up/down and its
    // state change land in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (decay) begin
                    w_state_nxt = (w_out_nxt != '0) ? DECAY : EXPIRED;
                end
            end
            DECAY: begin
                if (!decay) begin
                    w_state_nxt = IDLE;
                end else if (w_out_nxt == '0) begin
                    w_state_nxt = EXPIRED;
                end
            end
            EXPIRED: begin
                if (!decay) begin
                    w_state_nxt = IDLE;
                end else if (w_out_nxt != '0) begin
                    w_state_nxt = DECAY;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_out     <= '0;
            r_zero    <= 1'b1;
            r_halved  <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_out     <= w_out_nxt;
            r_zero    <= (w_out_nxt == '0);
            r_halved  <= w_halve;
            r_expired <= (w_state_nxt == EXPIRED);
        end
    end

    assign out     = r_out;
    assign zero    = r_zero;
    assign halved  = r_halved;
    assign expired = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_halflife_timer_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_halflife_timer_n
// Description : Directed vector bench for halflife_timer_n (saturating and
//               wrapping instances driven from the same stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_halflife_timer_n;

    typedef struct {
        logic       rst;
        logic       load;
        logic       up;
        logic       down;
        logic       decay;
        logic [7:0] din;
        logic [7:0] per;
        logic [7:0] eout;
        logic       ez;
        logic       eh;
        logic       ee;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       decay = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] period = 8'h00;

    logic [7:0] out_s;
    logic       zero_s, halved_s, expired_s;
    logic [7:0] out_w;
    logic       zero_w, halved_w, expired_w;

    int n_cmp = 0;
    int n_err = 0;

    vec_t vq[$];

    always #5 clk = ~clk;

    halflife_timer_n #(.WIDTH(8), .PRE_W(8), .WRAP(0)) u_dut_sat (
        .clk(clk), .rst(rst), .load(load), .up(up), .down(down), .decay(decay),
        .in(din), .period(period),
        .out(out_s), .zero(zero_s), .halved(halved_s), .expired(expired_s)
    );

    halflife_timer_n #(.WIDTH(8), .PRE_W(8), .WRAP(1)) u_dut_wrap (
        .clk(clk), .rst(rst), .load(load), .up(up), .down(down), .decay(decay),
        .in(din), .period(period),
        .out(out_w), .zero(zero_w), .halved(halved_w), .expired(expired_w)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic u, input logic d,
                         input logic dc, input logic [7:0] v, input logic [7:0] p);
        rst = r; load = l; up = u; down = d; decay = dc; din = v; period = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eo, input logic ez,
                           input logic eh, input logic ee);
        chk({tag, ".out"}, {24'd0, out_s}, {24'd0, eo});
        chk({tag, ".zero"}, {31'd0, zero_s}, {31'd0, ez});
        chk({tag, ".halved"}, {31'd0, halved_s}, {31'd0, eh});
        chk({tag, ".expired"}, {31'd0, expired_s}, {31'd0, ee});
    endtask

    initial begin
        logic [7:0] v;

        // rst load up down decay in per | out z h e
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'd0, 8'h00,1'b1,1'b0,1'b0});
        vq.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,8'hFF,8'd0, 8'hFF,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,8'd0, 8'hFF,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,8'h00,8'd0, 8'h00,1'b1,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,8'd0, 8'h00,1'b1,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b1,1'b1,1'b0,8'h00,8'd0, 8'h01,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0,8'h55,8'd0, 8'h55,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,8'd0, 8'h54,1'b0,1'b0,1'b0});
        // load+up with decay at period 0: load wins, then halvings every cycle
        vq.push_back('{1'b1,1'b1,1'b1,1'b0,1'b1,8'h08,8'd0, 8'h08,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'd0, 8'h04,1'b0,1'b1,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'd0, 8'h02,1'b0,1'b1,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'd0, 8'h01,1'b0,1'b1,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'd0, 8'h00,1'b1,1'b1,1'b1});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'd0, 8'h00,1'b1,1'b0,1'b1});
        // leave EXPIRED, re-arm with 0x03
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,8'd0, 8'h00,1'b1,1'b0,1'b0});
        vq.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,8'h03,8'd0, 8'h03,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'd0, 8'h01,1'b0,1'b1,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'd0, 8'h00,1'b1,1'b1,1'b1});
        // up while EXPIRED re-enters DECAY
        vq.push_back('{1'b1,1'b0,1'b1,1'b0,1'b1,8'h00,8'd0, 8'h01,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'd0, 8'h00,1'b1,1'b1,1'b1});
        // mid-decay reset with out=0x40, then decay goes straight to EXPIRED
        vq.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,8'h40,8'd3, 8'h40,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'd3, 8'h40,1'b0,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,8'h00,8'd3, 8'h00,1'b1,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'd3, 8'h00,1'b1,1'b0,1'b1});
        // period 1 spacing, and decay=0 leaving DECAY
        vq.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,8'h10,8'd1, 8'h10,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'd1, 8'h10,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'd1, 8'h10,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'd1, 8'h08,1'b0,1'b1,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,8'd1, 8'h08,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,8'd1, 8'h08,1'b0,1'b0,1'b0});

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].load, vq[i].up, vq[i].down, vq[i].decay,
                  vq[i].din, vq[i].per);
            chk_all($sformatf("vec%0d", i), vq[i].eout, vq[i].ez, vq[i].eh, vq[i].ee);
        end

        // Full A0 decay chain at period 3: one halving every 4 cycles
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 8'd3);
        chk_all("chain.load", 8'hA0, 1'b0, 1'b0, 1'b0);
        v = 8'hA0;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 3; c++) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd3);
                chk($sformatf("chain%0d.hold%0d", k, c), {24'd0, out_s}, {24'd0, v});
                chk($sformatf("chain%0d.nohalf%0d", k, c), {31'd0, halved_s}, 32'd0);
            end
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd3);
            v = v >> 1;
            chk_all($sformatf("chain%0d.halve", k), v, (v == 8'h00), 1'b1, (v == 8'h00));
        end

        // up on the tick cycle at period 7 drops the halving and restarts the interval
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd7);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 8'd7);
        for (int c = 0; c < 7; c++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd7);
        chk("pre7.hold", {24'd0, out_s}, 32'h20);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'd7);
        chk_all("pre7.up_on_tick", 8'h21, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd7);
            chk($sformatf("pre7.wait%0d", c), {24'd0, out_s}, 32'h21);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd7);
        chk_all("pre7.halve", 8'h10, 1'b0, 1'b1, 1'b0);

        // saturate versus wrap at both ends
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0);
        chk("sat.up_ff", {24'd0, out_s}, 32'hFF);
        chk("wrap.up_ff", {24'd0, out_w}, 32'h00);
        chk("wrap.up_ff.zero", {31'd0, zero_w}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0);
        chk("sat.down_00", {24'd0, out_s}, 32'h00);
        chk("wrap.down_00", {24'd0, out_w}, 32'hFF);
        chk("wrap.down_00.zero", {31'd0, zero_w}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
